// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO holding ALU result words, flags and commands,
// with a sticky overflow flag. Optional counters under ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic              in_carryout,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic [2:0]        in_command,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_carryout,
  output logic              out_zero,
  output logic              out_overflow,
  output logic [2:0]        out_command,
  output logic [ADDR_W:0]   count,
  output logic              sticky_overflow,
  input  logic              clear_sticky
`ifdef ALU_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]       push_count,
  output logic [15:0]       ovf_count,
  output logic [15:0]       full_stall_count
`endif
);

  localparam int ENTRY_W = 38;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wptr;
  logic [ADDR_W-1:0]  r_rptr;
  logic [ADDR_W:0]    r_count;
  logic               r_sticky;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  assign in_ready        = (r_count < CNT_DEPTH);
  assign out_valid       = (r_count != '0);
  assign count           = r_count;
  assign sticky_overflow = r_sticky;

  // A pop while full frees a slot only after the edge, so push depends on in_ready alone.
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign w_head       = out_valid ? r_mem[r_rptr] : '0;
  assign out_result   = w_head[31:0];
  assign out_carryout = w_head[32];
  assign out_zero     = w_head[33];
  assign out_overflow = w_head[34];
  assign out_command  = w_head[37:35];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_command, in_overflow, in_zero, in_carryout, in_result};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A new overflow in the same cycle as a clear must not be lost.
      if (w_push && in_overflow) begin
        r_sticky <= 1'b1;
      end else if (clear_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0] r_push_count;
  logic [15:0] r_ovf_count;
  logic [15:0] r_stall_count;

  assign push_count       = r_push_count;
  assign ovf_count        = r_ovf_count;
  assign full_stall_count = r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_push_count  <= '0;
      r_ovf_count   <= '0;
      r_stall_count <= '0;
    end else if (clear_sticky) begin
      r_push_count  <= '0;
      r_ovf_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_push && r_push_count != 16'hffff) begin
        r_push_count <= r_push_count + 16'd1;
      end
      if (w_push && in_overflow && r_ovf_count != 16'hffff) begin
        r_ovf_count <= r_ovf_count + 16'd1;
      end
      if (in_valid && !in_ready && r_stall_count != 16'hffff) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end
`endif

endmodule
